// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: single-outstanding request/grant/rvalid bus.
// The master side belongs to the pipeline stage, the slave side to the memory.
interface mem_access_stage_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req,
        output o_dmem_we,
        output o_dmem_addr,
        output o_dmem_be,
        output o_dmem_wdata,
        input  i_dmem_gnt,
        input  i_dmem_rvalid,
        input  i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req,
        input  o_dmem_we,
        input  o_dmem_addr,
        input  o_dmem_be,
        input  o_dmem_wdata,
        output i_dmem_gnt,
        output i_dmem_rvalid,
        output i_dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32IC MEM stage: aligns stores, extends loads, stalls until the data-memory
// access completes, and drives the MEM/WB register.
module mem_access_stage (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_valid,
    input  logic [31:0]               i_alu_out,
    input  logic [31:0]               i_write_reg,
    input  logic [31:0]               i_pc,
    input  logic [4:0]                i_rd,
    input  logic                      i_reg_write,
    input  logic                      i_mem_to_reg,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic [3:0]                i_mem_type,
    output logic                      o_stall,
    mem_access_stage_if.master        dmem,
    output logic                      o_wb_valid,
    output logic                      o_wb_reg_write,
    output logic [4:0]                o_wb_rd,
    output logic [31:0]               o_wb_data,
    output logic [31:0]               o_wb_pc,
    output logic                      o_misaligned
);

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  type_q, type_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic        misaligned_q, misaligned_d;

    logic        is_byte, is_half, is_word;
    logic [1:0]  off;
    logic        mem_op, bad_access, legal_op;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;
    logic [31:0] rdata_shift;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic        req, stall;

    assign off    = i_alu_out[1:0];
    assign mem_op = i_valid & (i_mem_read | i_mem_write);

    always_comb begin
        is_byte = (i_mem_type == 4'b0001) || (i_mem_type == 4'b1000);
        is_half = (i_mem_type == 4'b0011) || (i_mem_type == 4'b1100);
        is_word = (i_mem_type == 4'b1111);
    end

    // Illegal size codes fall through all three terms and fault like misalignment.
    assign bad_access = mem_op & ~(is_byte
                                 | (is_half & ~off[0])
                                 | (is_word & (off == 2'b00)));
    assign legal_op   = mem_op & ~bad_access;

    always_comb begin
        be_raw = 4'b1111;
        if (is_byte) begin
            be_raw = 4'b0001 << off;
        end else if (is_half) begin
            be_raw = 4'b0011 << off;
        end
    end

    // Replicate the store operand across lanes; the byte enables pick the lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            assign wdata_raw[8*gi +: 8] = is_byte ? i_write_reg[7:0] :
                                          is_half ? i_write_reg[8*(gi%2) +: 8] :
                                                    i_write_reg[8*gi +: 8];
        end
    endgenerate

    assign rdata_shift = dmem.i_dmem_rdata >> {off_q, 3'b000};
    assign half_lane   = off_q[1] ? dmem.i_dmem_rdata[31:16] : dmem.i_dmem_rdata[15:0];

    always_comb begin
        case (type_q)
            4'b0001: load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            4'b1000: load_ext = {24'h0, rdata_shift[7:0]};
            4'b0011: load_ext = {{16{half_lane[15]}}, half_lane};
            4'b1100: load_ext = {16'h0, half_lane};
            default: load_ext = dmem.i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        off_d          = off_q;
        type_d         = type_q;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_pc_d        = wb_pc_q;
        misaligned_d   = 1'b0;
        req            = 1'b0;
        stall          = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal_op) begin
                    req   = 1'b1;
                    stall = ~(i_mem_write & dmem.i_dmem_gnt);
                    if (dmem.i_dmem_gnt) begin
                        if (i_mem_write) begin
                            wb_valid_d     = 1'b1;
                            wb_reg_write_d = 1'b0;
                            wb_rd_d        = i_rd;
                            wb_data_d      = i_alu_out;
                            wb_pc_d        = i_pc;
                        end else begin
                            state_d = WAIT_R;
                            off_d   = off;
                            type_d  = i_mem_type;
                        end
                    end
                end else if (bad_access) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = 1'b0;
                    wb_rd_d        = i_rd;
                    wb_data_d      = i_alu_out;
                    wb_pc_d        = i_pc;
                    misaligned_d   = 1'b1;
                end else if (i_valid) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = i_reg_write;
                    wb_rd_d        = i_rd;
                    wb_data_d      = i_alu_out;
                    wb_pc_d        = i_pc;
                end
            end
            WAIT_R: begin
                // Upstream holds the instruction stable, so its fields are still valid here.
                stall = ~dmem.i_dmem_rvalid;
                if (dmem.i_dmem_rvalid) begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = i_reg_write;
                    wb_rd_d        = i_rd;
                    wb_data_d      = i_mem_to_reg ? load_ext : i_alu_out;
                    wb_pc_d        = i_pc;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= IDLE;
            off_q          <= 2'b00;
            type_q         <= 4'b0000;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= 32'h0;
            wb_pc_q        <= 32'h0;
            misaligned_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            off_q          <= off_d;
            type_q         <= type_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_pc_q        <= wb_pc_d;
            misaligned_q   <= misaligned_d;
        end
    end

    assign o_stall           = stall;
    assign dmem.o_dmem_req   = req;
    assign dmem.o_dmem_we    = req & i_mem_write;
    assign dmem.o_dmem_addr  = req ? {i_alu_out[31:2], 2'b00} : 32'h0;
    assign dmem.o_dmem_be    = req ? be_raw : 4'b0000;
    assign dmem.o_dmem_wdata = req ? wdata_raw : 32'h0;

    assign o_wb_valid     = wb_valid_q;
    assign o_wb_reg_write = wb_reg_write_q;
    assign o_wb_rd        = wb_rd_q;
    assign o_wb_data      = wb_data_q;
    assign o_wb_pc        = wb_pc_q;
    assign o_misaligned   = misaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a behavioural model checked every cycle
// on the falling edge, plus literal expectations for the key scenarios.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] alu = 32'h0;
    logic [31:0] wreg = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [4:0]  rd = 5'd0;
    logic        regw = 1'b0;
    logic        m2r = 1'b0;
    logic        mrd = 1'b0;
    logic        mwr = 1'b0;
    logic [3:0]  mtype = 4'b0000;
    logic        stall;
    logic        wbv, wbrw, mis;
    logic [4:0]  wbrd;
    logic [31:0] wbdata, wbpc;

    int n_checks = 0;
    int n_fail = 0;

    mem_access_stage_if dmem_bus();

    always #5 clk = ~clk;

    mem_access_stage dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_valid        (valid),
        .i_alu_out      (alu),
        .i_write_reg    (wreg),
        .i_pc           (pc),
        .i_rd           (rd),
        .i_reg_write    (regw),
        .i_mem_to_reg   (m2r),
        .i_mem_read     (mrd),
        .i_mem_write    (mwr),
        .i_mem_type     (mtype),
        .o_stall        (stall),
        .dmem           (dmem_bus),
        .o_wb_valid     (wbv),
        .o_wb_reg_write (wbrw),
        .o_wb_rd        (wbrd),
        .o_wb_data      (wbdata),
        .o_wb_pc        (wbpc),
        .o_misaligned   (mis)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sz_of(input logic [3:0] t);
        case (t)
            4'b0001, 4'b1000: return 1;
            4'b0011, 4'b1100: return 2;
            4'b1111:          return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] d, input int o, input int sz,
                                             input bit sg);
        logic [31:0] mask, lane;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        lane = (d >> (8 * o)) & mask;
        if (sg && sz < 4 && lane[8 * sz - 1]) lane = lane | ~mask;
        return lane;
    endfunction

    // Behavioural model: expected MEM/WB contents and whether a load is outstanding.
    bit          m_pending = 0;
    bit          m_dc = 0;
    logic        m_wbv = 0, m_rw = 0, m_mis = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_data = 0, m_pc = 0;

    always @(negedge clk) begin : compare
        int sz, off;
        bit ok, mem_op, e_req, e_stall, sg;
        if (!rst_n) begin
            m_pending = 0; m_dc = 0;
            m_wbv = 0; m_rw = 0; m_mis = 0; m_rd = 0; m_data = 0; m_pc = 0;
        end
        chk("wb_valid", wbv, m_wbv);
        chk("wb_reg_write", wbrw, m_rw);
        chk("misaligned", mis, m_mis);
        if (!m_dc) begin
            chk("wb_rd", wbrd, m_rd);
            chk("wb_data", wbdata, m_data);
            chk("wb_pc", wbpc, m_pc);
        end
        if (rst_n) begin
            sz = sz_of(mtype);
            sg = (mtype == 4'b0001) || (mtype == 4'b0011);
            off = int'(alu[1:0]);
            ok = 0;
            if (sz != 0) ok = (off % sz) == 0;
            mem_op = valid && (mrd || mwr);
            e_req = 0; e_stall = 0;
            if (m_pending) begin
                e_stall = !dmem_bus.i_dmem_rvalid;
            end else if (mem_op && ok) begin
                e_req = 1;
                e_stall = !(mwr && dmem_bus.i_dmem_gnt);
            end
            chk("dmem_req", dmem_bus.o_dmem_req, e_req);
            chk("stall", stall, e_stall);
            if (e_req) begin
                chk("dmem_we", dmem_bus.o_dmem_we, mwr);
                chk("dmem_addr", dmem_bus.o_dmem_addr, alu & 32'hFFFF_FFFC);
                chk("dmem_be", dmem_bus.o_dmem_be, 32'(((1 << sz) - 1) << off));
                if (mwr)
                    chk("dmem_wdata", dmem_bus.o_dmem_wdata,
                        (sz == 1) ? wreg[7:0] * 32'h0101_0101 :
                        (sz == 2) ? wreg[15:0] * 32'h0001_0001 : wreg);
            end
            m_mis = 0;
            m_wbv = 0;
            if (m_pending) begin
                if (dmem_bus.i_dmem_rvalid) begin
                    m_wbv = 1; m_rw = regw; m_rd = rd; m_pc = pc; m_dc = 0;
                    m_data = m2r ? load_val(dmem_bus.i_dmem_rdata, off, sz, sg) : alu;
                    m_pending = 0;
                end
            end else if (!valid) begin
                m_wbv = 0;
            end else if (mem_op && !ok) begin
                m_wbv = 1; m_rw = 0; m_mis = 1; m_dc = 1;
            end else if (!mem_op) begin
                m_wbv = 1; m_rw = regw; m_rd = rd; m_pc = pc; m_data = alu; m_dc = 0;
            end else if (mwr) begin
                if (dmem_bus.i_dmem_gnt) begin
                    m_wbv = 1; m_rw = 0; m_dc = 1;
                end
            end else if (dmem_bus.i_dmem_gnt) begin
                m_pending = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 0; mrd = 0; mwr = 0; mtype = 4'b0000; alu = 0; wreg = 0;
        rd = 0; regw = 0; m2r = 0; pc = 0;
        dmem_bus.i_dmem_gnt = 0; dmem_bus.i_dmem_rvalid = 0; dmem_bus.i_dmem_rdata = 0;
    endtask

    task automatic set_op(input bit r, input bit w, input logic [3:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] d, input bit rw,
                          input logic [31:0] p);
        valid = 1; mrd = r; mwr = w; mtype = t; alu = a; wreg = wd;
        rd = d; regw = rw; m2r = r; pc = p;
    endtask

    // Load with grant after gd cycles and rvalid rv cycles after the grant; counts stall cycles.
    task automatic do_load(input logic [3:0] t, input logic [31:0] a, input logic [31:0] rdata,
                           input int gd, input int rv, output int stalls);
        stalls = 0;
        set_op(1, 0, t, a, 32'h0, 5'd7, 1, 32'h0000_2000 + a);
        for (int k = 0; k <= gd + rv; k++) begin
            dmem_bus.i_dmem_gnt    = (k == gd);
            dmem_bus.i_dmem_rvalid = (k == gd + rv);
            dmem_bus.i_dmem_rdata  = (k == gd + rv) ? rdata : 32'hA5A5_A5A5;
            #1;
            if (stall) stalls++;
            tick();
        end
        idle();
    endtask

    initial begin
        int st;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_data", wbdata, 32'h0);
        chk("reset_wb_valid", wbv, 1'b0);
        chk("reset_req", dmem_bus.o_dmem_req, 1'b0);
        chk("reset_stall", stall, 1'b0);
        rst_n = 1;
        tick();

        // Non-memory ADD
        set_op(0, 0, 4'b0000, 32'h5, 32'h0, 5'd3, 1, 32'h1000);
        m2r = 0;
        #1 chk("add_stall", stall, 1'b0);
        tick();
        chk("add_wb_data", wbdata, 32'h5);
        chk("add_wb_rd", wbrd, 5'd3);
        chk("add_wb_valid", wbv, 1'b1);
        idle();
        tick();

        // SB 0x123456AB to 0x102, granted immediately
        set_op(0, 1, 4'b0001, 32'h102, 32'h1234_56AB, 5'd0, 0, 32'h1004);
        dmem_bus.i_dmem_gnt = 1;
        #1;
        chk("sb_addr", dmem_bus.o_dmem_addr, 32'h100);
        chk("sb_be", dmem_bus.o_dmem_be, 4'b0100);
        chk("sb_wdata", dmem_bus.o_dmem_wdata, 32'hABAB_ABAB);
        chk("sb_stall", stall, 1'b0);
        tick();
        chk("sb_wb_reg_write", wbrw, 1'b0);
        chk("sb_wb_valid", wbv, 1'b1);
        idle();

        // SH 0xCAFEBEEF to 0x206, grant one cycle late
        set_op(0, 1, 4'b0011, 32'h206, 32'hCAFE_BEEF, 5'd0, 0, 32'h1008);
        #1 chk("sh_wait_stall", stall, 1'b1);
        tick();
        dmem_bus.i_dmem_gnt = 1;
        #1;
        chk("sh_be", dmem_bus.o_dmem_be, 4'b1100);
        chk("sh_wdata", dmem_bus.o_dmem_wdata, 32'hBEEF_BEEF);
        tick();
        idle();

        // SW, granted immediately
        set_op(0, 1, 4'b1111, 32'h208, 32'h0123_4567, 5'd0, 0, 32'h100C);
        dmem_bus.i_dmem_gnt = 1;
        #1 chk("sw_be", dmem_bus.o_dmem_be, 4'b1111);
        tick();
        idle();

        // LH / LHU at 0x202
        do_load(4'b0011, 32'h202, 32'h8001_0000, 2, 1, st);
        chk("lh_stall_cycles", st, 3);
        chk("lh_data", wbdata, 32'hFFFF_8001);
        chk("lh_reg_write", wbrw, 1'b1);
        do_load(4'b1100, 32'h202, 32'h8001_0000, 2, 1, st);
        chk("lhu_data", wbdata, 32'h0000_8001);

        // LB / LBU lanes
        do_load(4'b0001, 32'h403, 32'h80FF_1234, 0, 2, st);
        chk("lb_data", wbdata, 32'hFFFF_FF80);
        do_load(4'b1000, 32'h402, 32'h80FF_1234, 1, 1, st);
        chk("lbu_data", wbdata, 32'h0000_00FF);
        chk("lbu_stall_cycles", st, 2);

        // Misaligned LW, illegal size code, misaligned SH
        set_op(1, 0, 4'b1111, 32'h301, 32'h0, 5'd9, 1, 32'h1010);
        #1 chk("lw_mis_req", dmem_bus.o_dmem_req, 1'b0);
        tick();
        chk("lw_mis_pulse", mis, 1'b1);
        chk("lw_mis_reg_write", wbrw, 1'b0);
        idle();
        tick();
        chk("mis_one_cycle", mis, 1'b0);
        set_op(0, 1, 4'b0010, 32'h300, 32'h0, 5'd0, 0, 32'h1014);
        tick();
        chk("illegal_type_pulse", mis, 1'b1);
        set_op(0, 1, 4'b0011, 32'h101, 32'h0, 5'd0, 0, 32'h1018);
        tick();
        chk("sh_mis_pulse", mis, 1'b1);
        idle();
        tick();

        // Reset while waiting for rvalid, then a stray rvalid
        set_op(1, 0, 4'b1111, 32'h500, 32'h0, 5'd4, 1, 32'h1020);
        dmem_bus.i_dmem_gnt = 1;
        tick();
        dmem_bus.i_dmem_gnt = 0;
        #1 chk("waitr_stall", stall, 1'b1);
        rst_n = 0;
        idle();
        #1;
        chk("rst_wb_valid", wbv, 1'b0);
        chk("rst_wb_data", wbdata, 32'h0);
        chk("rst_wb_pc", wbpc, 32'h0);
        tick();
        rst_n = 1;
        tick();
        dmem_bus.i_dmem_rvalid = 1;
        dmem_bus.i_dmem_rdata = 32'h5555_5555;
        #1 chk("stray_rvalid_stall", stall, 1'b0);
        tick();
        dmem_bus.i_dmem_rvalid = 0;
        chk("stray_wb_valid", wbv, 1'b0);
        chk("stray_wb_data", wbdata, 32'h0);

        do_load(4'b1111, 32'h400, 32'hDEAD_BEEF, 0, 1, st);
        chk("post_reset_lw", wbdata, 32'hDEAD_BEEF);
        chk("post_reset_lw_valid", wbv, 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) pipeline stage of the RV32IC core, directly downstream of the EX-stage ALU. It consumes the EX/MEM register contents (ALU result, store data, control bits, access size code) and performs loads and stores over a single-outstanding request/grant/rvalid data-memory port. It byte-aligns store data, sign- or zero-extends load data, and stalls the pipeline until the access completes. It drives the MEM/WB register consumed by write-back.

## Interface
- No parameters; address and data widths are fixed at 32 bits.

- i_clk  in  1  core clock; all state updates on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  EX/MEM register holds a valid instruction
- i_alu_out  in  32  ALU result; the effective address for loads and stores
- i_write_reg  in  32  store data (rs2)
- i_pc  in  32  instruction PC, passed through
- i_rd  in  5  destination register
- i_reg_write  in  1  instruction writes rd
- i_mem_to_reg  in  1  rd takes load data, not ALU result
- i_mem_read  in  1  load
- i_mem_write  in  1  store
- i_mem_type  in  4  access size code: 0001 = byte signed, 0011 = half signed, 1111 = word, 1000 = byte unsigned, 1100 = half unsigned; any other value is illegal
- o_stall  out  1  hold EX/MEM and all upstream stages this cycle
- o_dmem_req  out  1  data-memory request
- o_dmem_we  out  1  1 = store, 0 = load
- o_dmem_addr  out  32  word address: {i_alu_out[31:2], 2'b00}
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  load data valid this cycle
- i_dmem_rdata  in  32  load data word
- o_wb_valid  out  1  MEM/WB holds a valid instruction
- o_wb_reg_write  out  1  write rd in WB
- o_wb_rd  out  5  destination register
- o_wb_data  out  32  write-back value
- o_wb_pc  out  32  instruction PC
- o_misaligned  out  1  one-cycle pulse: the last instruction was a misaligned or illegal-size access

## Operation
- FSM states:
  - IDLE: accepts a new instruction.
  - WAIT_R: a load has been granted and the stage awaits rvalid.
- Memory op: i_valid & (i_mem_read | i_mem_write). i_mem_read and i_mem_write are never both 1.
- Misaligned or illegal: a half access with addr[0]=1, a word access with addr[1:0]≠0, or an illegal i_mem_type.
  - The stage issues no request.
  - At the next edge: o_wb_valid=1, o_wb_reg_write=0, o_misaligned=1.
- Non-memory op in IDLE:
  - o_stall=0.
  - At the next edge: o_wb_data=i_alu_out; o_wb_reg_write, o_wb_rd and o_wb_pc are copied from the inputs.
- Legal memory op in IDLE:
  - o_dmem_req=1 combinationally.
  - o_stall = ~(store & i_dmem_gnt). A granted load also keeps o_stall=1.
  - Store granted: MEM/WB is written at the next edge with o_wb_reg_write=0.
  - Load granted: the FSM moves to WAIT_R. Address offset, size and sign are latched internally.
- WAIT_R:
  - o_dmem_req=0.
  - o_stall = ~i_dmem_rvalid.
  - On rvalid: MEM/WB captures the extended load data (if i_mem_to_reg is 0, it captures i_alu_out instead), with o_wb_reg_write=i_reg_write. The FSM returns to IDLE.
- Byte enables, with off=addr[1:0]:
  - byte: 0001<<off
  - half: 0011<<off (off ∈ {0,2})
  - word: 1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: byte lane = rdata[8*off+:8]; half lane = rdata[16*off[1]+:16]. The lane is sign-extended for signed codes and zero-extended for unsigned codes.
- i_valid=0 in IDLE: o_wb_valid=0 at the next edge; the other MEM/WB fields hold.
- In IDLE, i_dmem_rvalid is ignored. This covers a stray rvalid after a reset.

## Timing
- Reset, asynchronous, any state:
  - FSM returns to IDLE.
  - o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_wb_pc, o_misaligned all clear to 0.
  - Combinational outputs read 0 while the inputs are idle.
  - A load in flight is abandoned.
- Latency:
  - Non-memory op and misaligned access: 1 cycle.
  - Store: 1 cycle plus grant wait cycles.
  - Load: grant cycle + rvalid cycle; minimum 2 cycles when rvalid follows gnt by 1.
- While o_stall=1 the inputs are held stable by upstream. o_dmem_req, addr, we, be and wdata stay constant until gnt.
- rvalid never arrives in the same cycle as the gnt of its own request; it arrives ≥1 cycle later.
- o_misaligned is high for exactly one cycle per faulting instruction.

## Test plan
- Non-memory op: ADD result 0x0000_0005, rd=3, reg_write=1 → o_stall never asserts; 1 cycle later o_wb_data=5, rd=3, o_wb_valid=1.
- Byte store: SB data 0x1234_56AB to 0x100 + 2, gnt in the same cycle → addr=0x100, be=0100, wdata=0xABAB_ABAB, o_stall=0; o_wb_reg_write=0.
- Signed half load: LH at 0x202, rdata=0x8001_0000, gnt delayed 2 cycles, rvalid 1 cycle later → o_stall high for 3 cycles; o_wb_data=0xFFFF_8001. The same access as LHU (1100) gives 0x0000_8001.
- Misaligned word load: LW at 0x301 → no o_dmem_req; next cycle o_misaligned=1, o_wb_reg_write=0.
- Reset mid-load: i_reset_n=0 while in WAIT_R; release; a stray rvalid follows → stage in IDLE, all MEM/WB outputs 0, rvalid ignored, next instruction processed normally.
